// File: rtl/shift_cmd_sequencer_pkg.sv
// Shared types for the shift command sequencer.
//   out_state_t : occupancy of the result register (empty / holding a result)
//   LR_LEFT/RIGHT : encoding of the rotate direction bit carried with a command
package shift_pkg;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

    localparam logic LR_LEFT  = 1'b0;
    localparam logic LR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_cmd_sequencer_if.sv
// Command and result handshake bundle for shift_cmd_sequencer.
//   in_valid/in_ready/in_data/in_amt/in_lr : rotate command push side
//   out_valid/out_ready/out_data           : registered result side
//   pending                                : command FIFO occupancy, 0..DEPTH
// master = producer/consumer environment, slave = the sequencer.
interface shift_cmd_if #(
    parameter int N     = 3,
    parameter int DEPTH = 4
);
    localparam int W     = 2 ** N;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic [N-1:0]     in_amt;
    logic             in_lr;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic [CNT_W-1:0] pending;

    modport master (
        output in_valid, in_data, in_amt, in_lr, out_ready,
        input  in_ready, out_valid, out_data, pending
    );

    modport slave (
        input  in_valid, in_data, in_amt, in_lr, out_ready,
        output in_ready, out_valid, out_data, pending
    );
endinterface

// File: rtl/shift_cmd_sequencer_fifo.sv
// Command FIFO: DEPTH entries of W bits, pointers wrap modulo DEPTH and the
// occupancy counter alone separates full from empty.
//   clk, reset_n (sync, active-low), flush (sync clear)
//   push/wdata : write request (ignored when full)
//   pop/rdata  : read request (ignored when empty); rdata shows the head
//   full, empty, count : occupancy status, all from registered state
module shift_cmd_fifo
    import shift_pkg::*;
#(
    parameter int W     = 12,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no clear; a write in a reset/flush cycle is discarded.
    always_ff @(posedge clk) begin
        if (reset_n && !flush && do_push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/shift_cmd_sequencer.sv
// Buffered rotate-command front end: commands are queued in a small FIFO,
// the head command is rotated combinationally and captured in a result
// register with its own valid/ready handshake.
//   clk      : sole clock
//   reset_n  : synchronous active-low reset
//   flush    : synchronous clear of FIFO and result register
//   bus      : shift_cmd_if.slave (command push, result pop, pending)
module shift_cmd_sequencer
    import shift_pkg::*;
#(
    parameter int N     = 3,
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       flush,
    shift_cmd_if.slave bus
);
    localparam int W  = 2 ** N;
    localparam int CW = W + N + 1;

    logic [CW-1:0] wdata;
    logic [CW-1:0] rdata;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [W-1:0]  data_p0;
    logic [N-1:0]  amt_p0;
    logic          lr_p0;
    logic [W-1:0]  rot_p0;
    logic [W-1:0]  out_data_p1;
    logic          out_vld_p1;
    out_state_t    state_q;
    out_state_t    state_d;

    function automatic logic [W-1:0] rev_bits(input logic [W-1:0] d);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = d[W-1-i];
        return r;
    endfunction

    // Log-depth barrel: stage i rotates right by 2**i when amt bit i is set.
    function automatic logic [W-1:0] rot_right(input logic [W-1:0] d,
                                               input logic [N-1:0] a);
        logic [W-1:0]   r;
        logic [2*W-1:0] t;
        r = d;
        for (int i = 0; i < N; i++) begin
            if (a[i]) begin
                t = {r, r} >> (1 << i);
                r = t[W-1:0];
            end
        end
        return r;
    endfunction

    assign wdata        = {bus.in_data, bus.in_amt, bus.in_lr};
    assign push         = bus.in_valid && !full;
    assign pop          = !empty && (!out_vld_p1 || bus.out_ready);
    assign bus.in_ready = !full;

    shift_cmd_fifo #(
        .W     (CW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .push    (push),
        .pop     (pop),
        .wdata   (wdata),
        .rdata   (rdata),
        .full    (full),
        .empty   (empty),
        .count   (bus.pending)
    );

    // ---- stage p0: FIFO head -> barrel shifter/reverser (combinational) ----
    assign {data_p0, amt_p0, lr_p0} = rdata;

    always_comb begin
        rot_p0 = data_p0;
        case (lr_p0)
            LR_RIGHT: rot_p0 = rot_right(data_p0, amt_p0);
            LR_LEFT:  rot_p0 = rev_bits(rot_right(rev_bits(data_p0), amt_p0));
            default:  rot_p0 = data_p0;
        endcase
    end

    // ---- stage p1: result register and its occupancy FSM ----
    always_comb begin
        state_d = state_q;
        case (state_q)
            OUT_EMPTY: if (pop) state_d = OUT_FULL;
            OUT_FULL:  if (bus.out_ready && !pop) state_d = OUT_EMPTY;
            default:   state_d = OUT_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n || flush) state_q <= OUT_EMPTY;
        else                   state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!reset_n || flush) out_data_p1 <= '0;
        else if (pop)          out_data_p1 <= rot_p0;
    end

    assign out_vld_p1    = (state_q == OUT_FULL);
    assign bus.out_valid = out_vld_p1;
    assign bus.out_data  = out_data_p1;
endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// Directed bench for shift_cmd_sequencer (N=3, DEPTH=4) with a result
// scoreboard that follows every accepted command to the output.
module tb_shift_cmd_sequencer;
    localparam int N     = 3;
    localparam int DEPTH = 4;
    localparam int W     = 2 ** N;

    logic clk;
    logic reset_n;
    logic flush;

    int n_checks  = 0;
    int n_fail    = 0;
    int n_results = 0;
    int cyc       = 0;
    logic [W-1:0] exp_q [$];

    shift_cmd_if #(.N(N), .DEPTH(DEPTH)) bus ();

    shift_cmd_sequencer #(.N(N), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Independent reference rotate built from plain shifts.
    function automatic logic [W-1:0] rot_model(input logic [W-1:0] d,
                                               input logic [N-1:0] a,
                                               input logic lr);
        logic [W-1:0] r;
        if (lr) r = (d >> a) | (d << (W - int'(a)));
        else    r = (d << a) | (d >> (W - int'(a)));
        return r;
    endfunction

    // Observe the handshakes of the current cycle, then advance one clock.
    task automatic tick();
        logic [W-1:0] e;
        if (!reset_n || flush) begin
            exp_q.delete();
        end else begin
            if (bus.in_valid && bus.in_ready)
                exp_q.push_back(rot_model(bus.in_data, bus.in_amt, bus.in_lr));
            if (bus.out_valid && bus.out_ready) begin
                check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("sb_data", 32'(bus.out_data), 32'(e));
                    n_results++;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input logic [W-1:0] d, input logic [N-1:0] a, input logic lr);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_amt   = a;
        bus.in_lr    = lr;
    endtask

    task automatic push_cmd(input logic [W-1:0] d, input logic [N-1:0] a, input logic lr);
        logic acc;
        acc = 1'b0;
        drive(d, a, lr);
        for (int i = 0; i < 20 && !acc; i++) begin
            acc = bus.in_ready;
            tick();
        end
        bus.in_valid = 1'b0;
        check("push_accept", 32'(acc), 32'd1);
    endtask

    task automatic drain(input int max_cyc);
        logic acc;
        int c;
        c = 0;
        bus.out_ready = 1'b1;
        while ((bus.in_valid || exp_q.size() != 0) && c < max_cyc) begin
            acc = bus.in_valid && bus.in_ready;
            tick();
            if (acc) bus.in_valid = 1'b0;
            c++;
        end
        check("drain_done", 32'(exp_q.size()) + 32'(bus.in_valid), 32'd0);
        check("drain_out_valid", 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        int accepted;
        int r0;
        int c0;
        logic [W-1:0] bp_data [6];
        bp_data = '{8'h01, 8'h80, 8'hF0, 8'h3C, 8'hA5, 8'h96};

        reset_n       = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'hFF;
        bus.in_amt    = 3'd1;
        bus.in_lr     = 1'b1;
        bus.out_ready = 1'b1;

        // Reset held two cycles with a command offered.
        tick();
        tick();
        reset_n      = 1'b1;
        bus.in_valid = 1'b0;
        check("rst_pending",   32'(bus.pending),   32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data",  32'(bus.out_data),  32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);

        // Single right rotate, two-cycle latency.
        drive(8'b1000_0001, 3'd1, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        check("lat_k_out_valid", 32'(bus.out_valid), 32'd0);
        check("lat_k_pending",   32'(bus.pending),   32'd1);
        tick();
        check("lat_k1_out_valid", 32'(bus.out_valid), 32'd1);
        check("lat_k1_out_data",  32'(bus.out_data),  32'h0000_00C0);
        check("lat_k1_pending",   32'(bus.pending),   32'd0);
        tick();

        // Left rotate followed by amt=0 pass-through.
        drive(8'hA5, 3'd3, 1'b0);
        tick();
        drive(8'h5A, 3'd0, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        check("rotl_valid", 32'(bus.out_valid), 32'd1);
        check("rotl_data",  32'(bus.out_data),  32'h0000_002D);
        tick();
        check("amt0_data",  32'(bus.out_data),  32'h0000_005A);
        tick();
        check("drain_valid_clr", 32'(bus.out_valid), 32'd0);
        check("drain_data_keep", 32'(bus.out_data),  32'h0000_005A);

        // Backpressure: six commands offered against a stalled consumer.
        bus.out_ready = 1'b0;
        accepted = 0;
        for (int c = 0; c < 6; c++) begin
            drive(bp_data[c], 3'(c + 1), ~c[0]);
            if (bus.in_ready) accepted++;
            if (c < 5) tick();
        end
        check("bp_accepted",  32'(accepted),      32'd5);
        check("bp_in_ready",  32'(bus.in_ready),  32'd0);
        check("bp_pending",   32'(bus.pending),   32'd4);
        check("bp_out_valid", 32'(bus.out_valid), 32'd1);
        check("bp_hold_data", 32'(bus.out_data),  32'(rot_model(8'h01, 3'd1, 1'b1)));
        r0 = n_results;
        drain(40);
        check("bp_results", 32'(n_results - r0), 32'd6);

        // Simultaneous push and pop at pending=2.
        bus.out_ready = 1'b0;
        push_cmd(8'h12, 3'd2, 1'b1);
        push_cmd(8'h34, 3'd5, 1'b0);
        push_cmd(8'h56, 3'd7, 1'b1);
        check("pp_pending_before", 32'(bus.pending),   32'd2);
        check("pp_out_valid",      32'(bus.out_valid), 32'd1);
        drive(8'h78, 3'd4, 1'b0);
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("pp_pending_after", 32'(bus.pending), 32'd2);
        drain(20);

        // Pointer wrap over 3*DEPTH commands at full throughput.
        r0 = n_results;
        c0 = cyc;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3 * DEPTH; i++)
            push_cmd(8'(i * 37 + 11), 3'(i), i[1]);
        check("wrap_throughput", 32'(cyc - c0), 32'(3 * DEPTH));
        drain(20);
        check("wrap_results", 32'(n_results - r0), 32'(3 * DEPTH));

        // Flush mid-burst with a push in the flush cycle.
        bus.out_ready = 1'b0;
        push_cmd(8'hC3, 3'd1, 1'b0);
        push_cmd(8'h0F, 3'd2, 1'b1);
        push_cmd(8'hE7, 3'd3, 1'b0);
        push_cmd(8'h18, 3'd6, 1'b1);
        check("fl_pre_pending",   32'(bus.pending),   32'd3);
        check("fl_pre_out_valid", 32'(bus.out_valid), 32'd1);
        flush = 1'b1;
        drive(8'h99, 3'd1, 1'b1);
        tick();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        check("fl_pending",   32'(bus.pending),   32'd0);
        check("fl_out_valid", 32'(bus.out_valid), 32'd0);
        check("fl_out_data",  32'(bus.out_data),  32'd0);
        check("fl_in_ready",  32'(bus.in_ready),  32'd1);
        tick();
        tick();
        check("fl_push_discard_valid",   32'(bus.out_valid), 32'd0);
        check("fl_push_discard_pending", 32'(bus.pending),   32'd0);

        // Recovery after flush.
        bus.out_ready = 1'b1;
        push_cmd(8'h81, 3'd7, 1'b0);
        tick();
        check("post_fl_data", 32'(bus.out_data), 32'h0000_00C0);
        drain(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/shift_cmd_sequencer.md
# shift_cmd_sequencer

Buffered command front end for the multi-bit barrel shifter/reverser datapath. Accepts rotate commands (data, amount, direction) over a valid/ready handshake, holds them in a small FIFO, and presents the head command to an internal barrel shifter. Each shifter result is captured in an output register with its own valid/ready handshake. The block sits between the switch/button capture logic and the display/consumer stage, so bursts of commands never drop and results are always registered.

## Interface
- `N`, 3: log2 of data width; data is 2**N bits, amount is N bits.
- `DEPTH`, 4: command FIFO entries; a power of two, at least 2.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `flush`  in  1  synchronous clear of FIFO and output register; has lower priority than reset.
- `in_valid`  in  1  command present.
- `in_ready`  out  1  FIFO can accept; equals !full.
- `in_data`  in  2**N  operand.
- `in_amt`  in  N  rotate amount, 0..2**N-1.
- `in_lr`  in  1  1 = rotate right, 0 = rotate left.
- `out_valid`  out  1  result register holds a result.
- `out_ready`  in  1  consumer accepts the result.
- `out_data`  out  2**N  rotated result.
- `pending`  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.

## Operation
- Push: fires when `in_valid && in_ready`. Writes {data, amt, lr} at the write pointer.
- Pop condition: `!empty && (!out_valid || out_ready)`. Reads the head command, rotates it, and loads the result into `out_data`. Sets `out_valid`.
- Output drain: `out_ready && out_valid` with no pop clears `out_valid`. `out_data` keeps its last value.
- Rotation is a true rotate of 2**N bits, not a logical shift. Left rotate is built as reverse, then rotate right, then reverse. amt=0 passes data unchanged.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. The full/empty distinction comes from the `pending` counter.
- `pending` changes by +1 on push only, -1 on pop only, and is unchanged on push and pop in the same cycle.
- Simultaneous push and pop is legal whenever the FIFO is not full.
- When full, `in_ready`=0 even if a pop occurs that same cycle. There is no same-cycle pass-through.
- FSM on the output register has two states:
  - OUT_EMPTY: moves to OUT_FULL on pop.
  - OUT_FULL: stays on (out_ready && pop) or !out_ready. Moves to OUT_EMPTY on out_ready && !pop.
- `flush` and reset behave identically: pointers=0, `pending`=0, `out_valid`=0, `out_data`=0, state OUT_EMPTY. A push or pop in the same cycle as flush/reset is discarded.
- Stimulus held while `in_ready`=0 must stay stable. Commands are never dropped or duplicated.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_data`=0, `pending`=0.
- Latency: a command pushed at edge k, with the FIFO empty and the output free, gives `out_valid`=1 with its result after edge k+1, so 2 cycles from input to output.
- Throughput: 1 command per cycle when `out_ready` is held at 1.
- `in_ready` and `pending` are pure functions of registered state. There is no combinational path from `in_valid` or `out_ready` to `in_ready`.
- The shifter path is combinational from the FIFO read port to the output register D input.

## Structure
- Package `shift_pkg`:
  - `out_state_t` enum {OUT_EMPTY, OUT_FULL}.
  - Localparams `LR_LEFT`=1'b0 and `LR_RIGHT`=1'b1.
- Sub-module `shift_cmd_fifo`: parameterized by width and DEPTH. Has push, pop, full, empty and count ports.
- The top instantiates `shift_cmd_fifo`, the existing multi-bit barrel shifter/reverser, the output register and the FSM.

## Test plan
- Reset: drive `reset_n`=0 for 2 cycles with `in_valid`=1 -> `pending`=0, `out_valid`=0, `out_data`=0 after release.
- Single command, N=3, data=8'b1000_0001, amt=1, lr=1, `out_ready`=1 -> `out_data`=8'b1100_0000 exactly 2 cycles after the push.
- Left rotate and amt=0: data=8'hA5, amt=3, lr=0 -> 8'h2D; then data=8'h5A, amt=0, lr=1 -> 8'h5A.
- Backpressure: hold `out_ready`=0 and push 6 commands -> 5 accepted (4 in the FIFO plus 1 in the output register) and `in_ready`=0. Release `out_ready` -> results emerge in push order, with no loss or duplication.
- Simultaneous push and pop with `pending`=2 -> `pending` stays 2. Pointer wrap is exercised over 3×DEPTH commands and results match a reference rotate model.
- `flush` asserted mid-burst with `out_valid`=1 and `pending`=3 -> next cycle `pending`=0 and `out_valid`=0. A push in the flush cycle is discarded.
